// File: rtl/seven_segment_multiplexer.sv
// Multiplexed hex display driver for a row of w_digit seven-segment digits.
// One digit is lit at a time for cycles_per_digit clocks; a full pass over all
// digits is one frame. Values are captured into shadow registers on a strobe
// and copied into the display registers only at the frame boundary, so a
// frame never mixes two different values.
// Optional feature macro: SEVEN_SEGMENT_MULTIPLEXER_LEADING_ZERO_BLANK_EN
// blanks the segments (not the dot) of leading zero digits.

module seven_segment_multiplexer #(
  parameter int clk_mhz          = 50,
  parameter int w_digit          = 8,
  parameter int refresh_hz       = 1000,
  parameter int cycles_per_digit = clk_mhz * 1000000 / (refresh_hz * w_digit)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*w_digit-1:0]   number,
  input  logic                   number_valid,
  input  logic [w_digit-1:0]     dots,
  input  logic [w_digit-1:0]     digit_en,
  output logic [7:0]             abcdefgh,
  output logic [w_digit-1:0]     digit,
  output logic                   frame_start
);

  // Capture protocol: number_valid is a single-cycle strobe with no ready
  // side. Whenever it is high on a rising edge, number, dots and digit_en are
  // taken together into the shadow registers; a later strobe in the same
  // frame simply overwrites an earlier one. The strobe is never refused.

  localparam int dwell = (cycles_per_digit < 1) ? 1 : cycles_per_digit;
  localparam int cnt_w = (dwell > 1) ? $clog2(dwell) : 1;
  localparam int idx_w = (w_digit > 1) ? $clog2(w_digit) : 1;
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(dwell - 1);
  localparam logic [idx_w-1:0] idx_last = idx_w'(w_digit - 1);

  logic [cnt_w-1:0]     cnt;
  logic [idx_w-1:0]     idx;
  logic                 cnt_wrap;
  logic                 frame_wrap;

  logic [4*w_digit-1:0] shadow_num;
  logic [w_digit-1:0]   shadow_dots;
  logic [w_digit-1:0]   shadow_en;
  logic [4*w_digit-1:0] disp_num;
  logic [w_digit-1:0]   disp_dots;
  logic [w_digit-1:0]   disp_en;

  logic [3:0]           cur_nib;
  logic                 cur_dot;
  logic                 cur_en;
  logic                 cur_lz;
  logic [6:0]           seg_hex;
  logic [7:0]           seg_next;
  logic [w_digit-1:0]   digit_next;

  assign cnt_wrap   = (cnt == cnt_last);
  assign frame_wrap = cnt_wrap && (idx == idx_last);

  // Dwell counter and digit index: index steps once per dwell wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt_wrap) begin
      cnt <= '0;
      idx <= (idx == idx_last) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow registers: follow every strobe, last one wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_num  <= '0;
      shadow_dots <= '0;
      shadow_en   <= '0;
    end else if (number_valid) begin
      shadow_num  <= number;
      shadow_dots <= dots;
      shadow_en   <= digit_en;
    end
  end

  // Display registers: reload only as the index wraps to digit 0. A strobe in
  // that same cycle lands in the shadow and shows one frame later.
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_num  <= '0;
      disp_dots <= '0;
      disp_en   <= '0;
    end else if (frame_wrap) begin
      disp_num  <= shadow_num;
      disp_dots <= shadow_dots;
      disp_en   <= shadow_en;
    end
  end

  // Select the nibble, dot and enable of the current digit; build its one-hot.
  always_comb begin
    cur_nib    = 4'd0;
    cur_dot    = 1'b0;
    cur_en     = 1'b0;
    digit_next = '0;
    for (int i = 0; i < w_digit; i++) begin
      if (idx == idx_w'(i)) begin
        cur_nib       = disp_num[i*4 +: 4];
        cur_dot       = disp_dots[i];
        cur_en        = disp_en[i];
        digit_next[i] = 1'b1;
      end
    end
  end

`ifdef SEVEN_SEGMENT_MULTIPLEXER_LEADING_ZERO_BLANK_EN
  logic [w_digit-1:0] lz_mask;
  logic               lz_run;

  // Mark zero digits above the highest enabled nonzero digit; digit 0 is
  // never marked so a plain zero still shows.
  always_comb begin
    lz_run  = 1'b1;
    lz_mask = '0;
    for (int i = w_digit - 1; i >= 1; i--) begin
      if (disp_en[i] && (disp_num[i*4 +: 4] != 4'd0)) begin
        lz_run = 1'b0;
      end
      lz_mask[i] = lz_run && (disp_num[i*4 +: 4] == 4'd0);
    end
  end

  assign cur_lz = |(lz_mask & digit_next);
`else
  assign cur_lz = 1'b0;
`endif

  // Hex to segments a..g (bit 6 = a, bit 0 = g).
  always_comb begin
    seg_hex = 7'b0000000;
    case (cur_nib)
      4'h0: seg_hex = 7'b1111110;
      4'h1: seg_hex = 7'b0110000;
      4'h2: seg_hex = 7'b1101101;
      4'h3: seg_hex = 7'b1111001;
      4'h4: seg_hex = 7'b0110011;
      4'h5: seg_hex = 7'b1011011;
      4'h6: seg_hex = 7'b1011111;
      4'h7: seg_hex = 7'b1110000;
      4'h8: seg_hex = 7'b1111111;
      4'h9: seg_hex = 7'b1111011;
      4'hA: seg_hex = 7'b1110111;
      4'hB: seg_hex = 7'b0011111;
      4'hC: seg_hex = 7'b1001110;
      4'hD: seg_hex = 7'b0111101;
      4'hE: seg_hex = 7'b1001111;
      4'hF: seg_hex = 7'b1000111;
      default: seg_hex = 7'b0000000;
    endcase
  end

  // Disabled digits go fully dark; leading-zero blanking keeps the dot.
  always_comb begin
    seg_next = 8'h00;
    if (cur_en) begin
      seg_next = {(cur_lz ? 7'b0000000 : seg_hex), cur_dot};
    end
  end

  // Registered outputs, one cycle behind the index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      abcdefgh    <= 8'h00;
      digit       <= '0;
      frame_start <= 1'b0;
    end else begin
      abcdefgh    <= seg_next;
      digit       <= digit_next;
      frame_start <= (idx == '0) && (cnt == '0);
    end
  end

endmodule
